// File: rtl/ps2_key_sequencer_if.sv
// Keyboard-side bus for ps2_key_sequencer: receiver FIFO handshake plus
// decoded key-event outputs. master = sequencer, slave = receiver/consumer side.
interface ps2_key_sequencer_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_held;
  logic [7:0] held_code;
  logic       held_ext;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter_valid;
  logic [7:0] key_count;

  modport master (
    input  kbd_data, kbd_ready,
    output kbd_nextdata_n, key_valid, key_code, key_ext, key_break,
           key_held, held_code, held_ext, digit_valid, digit,
           enter_valid, key_count
  );

  modport slave (
    output kbd_data, kbd_ready,
    input  kbd_nextdata_n, key_valid, key_code, key_ext, key_break,
           key_held, held_code, held_ext, digit_valid, digit,
           enter_valid, key_count
  );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Drains PS/2 scan-code bytes, merges E0/F0 prefixes into key events, filters
// typematic repeats, tracks the held key and decodes digit/Enter presses.
module ps2_key_sequencer #(
  parameter int unsigned TIMEOUT_CYC   = 2500000,
  parameter bit          REPEAT_FILTER = 1'b1
) (
  input  logic                  clk,
  input  logic                  clrn,
  ps2_key_sequencer_if.master   kbd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_GAP
  } state_t;

  localparam int unsigned    CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t          r_state;
  logic            r_nextdata_n;
  logic            r_ext_pend;
  logic            r_brk_pend;
  logic [CW-1:0]   r_to_cnt;
  logic            r_key_valid;
  logic [7:0]      r_key_code;
  logic            r_key_ext;
  logic            r_key_break;
  logic            r_key_held;
  logic [7:0]      r_held_code;
  logic            r_held_ext;
  logic            r_digit_valid;
  logic [3:0]      r_digit;
  logic            r_enter_valid;
  logic [7:0]      r_key_count;

  logic            w_accept;
  logic            w_is_e0;
  logic            w_is_f0;
  logic            w_discard;
  logic            w_event;
  logic            w_same_held;
  logic            w_make_emit;
  logic            w_break_emit;
  logic            w_digit_hit;
  logic [3:0]      w_digit_val;
  logic            w_is_enter;

  // The head byte is decoded at the edge that latches it, so the registered
  // event outputs are visible during the POP cycle alongside the pop strobe.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && kbd.kbd_ready;
    w_is_e0   = (kbd.kbd_data == 8'hE0);
    w_is_f0   = (kbd.kbd_data == 8'hF0);
    w_discard = 1'b0;
    case (kbd.kbd_data)
      8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: w_discard = 1'b1;
      default:                                  w_discard = 1'b0;
    endcase
    w_event      = w_accept && !w_is_e0 && !w_is_f0 && !w_discard;
    w_same_held  = r_key_held && (kbd.kbd_data == r_held_code) && (r_ext_pend == r_held_ext);
    w_make_emit  = w_event && !r_brk_pend && !(REPEAT_FILTER && w_same_held);
    w_break_emit = w_event && r_brk_pend;
    w_is_enter   = (kbd.kbd_data == 8'h5A);
  end

  always_comb begin
    w_digit_hit = 1'b1;
    w_digit_val = 4'd0;
    case (kbd.kbd_data)
      8'h45:   w_digit_val = 4'd0;
      8'h16:   w_digit_val = 4'd1;
      8'h1E:   w_digit_val = 4'd2;
      8'h26:   w_digit_val = 4'd3;
      8'h25:   w_digit_val = 4'd4;
      8'h2E:   w_digit_val = 4'd5;
      8'h36:   w_digit_val = 4'd6;
      8'h3D:   w_digit_val = 4'd7;
      8'h3E:   w_digit_val = 4'd8;
      8'h46:   w_digit_val = 4'd9;
      default: w_digit_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= S_IDLE;
      r_nextdata_n  <= 1'b1;
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_to_cnt      <= '0;
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
      r_key_ext     <= 1'b0;
      r_key_break   <= 1'b0;
      r_key_held    <= 1'b0;
      r_held_code   <= '0;
      r_held_ext    <= 1'b0;
      r_digit_valid <= 1'b0;
      r_digit       <= '0;
      r_enter_valid <= 1'b0;
      r_key_count   <= '0;
    end else begin
      r_key_valid   <= 1'b0;
      r_digit_valid <= 1'b0;
      r_enter_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (kbd.kbd_ready) begin
            r_state      <= S_POP;
            r_nextdata_n <= 1'b0;
          end
        end
        S_POP: begin
          r_state      <= S_GAP;
          r_nextdata_n <= 1'b1;
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_nextdata_n <= 1'b1;
        end
      endcase

      // A popped byte takes priority over a prefix timeout on the same edge.
      if (w_accept) begin
        r_to_cnt <= '0;
        if (w_is_e0) begin
          r_ext_pend <= 1'b1;
        end else if (w_is_f0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end else if (r_ext_pend || r_brk_pend) begin
        if (r_to_cnt == TO_LAST) begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
          r_to_cnt   <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end

      if (w_make_emit) begin
        r_key_valid <= 1'b1;
        r_key_code  <= kbd.kbd_data;
        r_key_ext   <= r_ext_pend;
        r_key_break <= 1'b0;
        r_key_held  <= 1'b1;
        r_held_code <= kbd.kbd_data;
        r_held_ext  <= r_ext_pend;
        r_key_count <= r_key_count + 8'd1;
        if (!r_ext_pend && w_digit_hit) begin
          r_digit_valid <= 1'b1;
          r_digit       <= w_digit_val;
        end
        if (!r_ext_pend && w_is_enter) begin
          r_enter_valid <= 1'b1;
        end
      end

      if (w_break_emit) begin
        r_key_valid <= 1'b1;
        r_key_code  <= kbd.kbd_data;
        r_key_ext   <= r_ext_pend;
        r_key_break <= 1'b1;
        if (w_same_held) begin
          r_key_held <= 1'b0;
        end
      end
    end
  end

  assign kbd.kbd_nextdata_n = r_nextdata_n;
  assign kbd.key_valid      = r_key_valid;
  assign kbd.key_code       = r_key_code;
  assign kbd.key_ext        = r_key_ext;
  assign kbd.key_break      = r_key_break;
  assign kbd.key_held       = r_key_held;
  assign kbd.held_code      = r_held_code;
  assign kbd.held_ext       = r_held_ext;
  assign kbd.digit_valid    = r_digit_valid;
  assign kbd.digit          = r_digit;
  assign kbd.enter_valid    = r_enter_valid;
  assign kbd.key_count      = r_key_count;

endmodule
